// File: rtl/alu_muldiv.sv
// Iterative RV32M-style multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, followed by a sign-fix cycle and a held result.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               a_neg_s, b_neg_s, div_zero_s, div_ovf_s, special_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s, special_res_s, fix_res_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_s;

    // Operand magnitudes, signs and special-case detection for the accept cycle.
    always_comb begin
        a_neg_s    = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM))
                     && a[WIDTH-1];
        b_neg_s    = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && b[WIDTH-1];
        a_mag_s    = a_neg_s ? -a : a;
        b_mag_s    = b_neg_s ? -b : b;
        div_zero_s = op[2] && (b == '0);
        div_ovf_s  = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
        special_s  = div_zero_s || div_ovf_s;
        if (div_zero_s) begin
            special_res_s = op[1] ? a : '1;
        end else if (div_ovf_s) begin
            special_res_s = op[1] ? '0 : a;
        end else begin
            special_res_s = '0;
        end
    end

    // One iteration of shift-add multiply and restoring divide; acc holds {hi, lo}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
        div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        div_ge_s    = (div_shift_s >= {1'b0, b_q});
        div_next_s  = {(div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge_s};
    end

    // Sign correction and result-half selection applied in FIX.
    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        case (op_q)
            OP_MUL:                         fix_res_s = prod_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_res_s = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:                fix_res_s = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            OP_REM, OP_REMU:                fix_res_s = neg_q ? -acc_q[2*WIDTH-1:WIDTH]
                                                              : acc_q[2*WIDTH-1:WIDTH];
            default:                        fix_res_s = '0;
        endcase
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !kill) begin
                    op_d  = op;
                    cnt_d = '0;
                    neg_d = (op == OP_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
                    if (special_s) begin
                        acc_d    = '0;
                        b_d      = '0;
                        result_d = special_res_s;
                        state_d  = ST_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag_s};
                        b_d     = b_mag_s;
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next_s : mul_next_s;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_FIX: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = fix_res_s;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // kill outranks the result handshake; either way the result is dropped to zero.
                if (kill || out_ready) begin
                    result_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                result_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and randomized checks of alu_muldiv (WIDTH=32 and WIDTH=8) using a result scoreboard.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, kill, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        in_valid_8, in_ready_8, kill_8, out_valid_8, out_ready_8, busy_8;
    logic [2:0]  op_8;
    logic [7:0]  a_8, b_8, result_8;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] sb8_q[$];

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    alu_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .op(op_8), .a(a_8),
        .b(b_8), .kill(kill_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .result(result_8), .busy(busy_8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference built on 64-bit arithmetic.
    function automatic logic [31:0] ref32(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] sx, sy, sp;
        logic [63:0] p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
            3'd1: begin sp = sx * sy; p = sp; return p[63:32]; end
            3'd2: begin sp = sx * $signed({32'd0, y}); p = sp; return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                sp = sx / sy; p = sp; return p[31:0];
            end
            3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                sp = sx % sy; p = sp; return p[31:0];
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x,
                                      input logic [31:0] y);
        return o[2] && ((y == 32'd0) ||
               (!o[0] && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)));
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        exp_t e;
        int   lat;
        bit   zero_ok;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b1;
        e.res = exp_res;
        e.lat = exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        zero_ok  = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (result !== 32'd0) zero_ok = 1'b0;
        end
        e = sb_q.pop_front();
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_result"}, result, e.res);
        if (e.lat > 1) chk({tag, "_zero_while_busy"}, zero_ok, 1);
        @(negedge clk);
        chk({tag, "_idle_after"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [7:0]  exp8;
        int          lat, held;
        bit          seen, stable;

        rst = 1'b1;
        in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1; op = 3'd0; a = 32'd0; b = 32'd0;
        in_valid_8 = 1'b0; kill_8 = 1'b0; out_ready_8 = 1'b0; op_8 = 3'd0; a_8 = 8'd0; b_8 = 8'd0;
        #2;
        chk("reset_flags32", {in_ready, busy, out_valid}, 3'b100);
        chk("reset_result32", result, 32'd0);
        chk("reset_flags8", {in_ready_8, busy_8, out_valid_8}, 3'b100);
        @(negedge clk);
        rst = 1'b0;

        run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 34, "mul");
        run_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh");
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "mulhsu");
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34, "mulhu");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_neg");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_neg");
        run_op(3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, "divu_zero");
        run_op(3'b111, 32'd7, 32'd0, 32'd7, 1, "remu_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, "rem_negdiv");

        for (int i = 0; i < 12; i++) begin
            o = 3'(i % 8);
            x = $urandom;
            y = (i == 9) ? 32'd0 : $urandom;
            if (i % 3 == 1) y = {28'd0, y[3:0]} + 32'd1;
            run_op(o, x, y, ref32(o, x, y), is_special(o, x, y) ? 1 : 34, "rand");
        end

        // kill during CALC
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; a = 32'd123; b = 32'd456;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_calc_flags", {in_ready, out_valid, busy}, 3'b100);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("kill_no_result", seen, 0);
        run_op(3'b000, 32'd3, 32'd5, 32'd15, 34, "mul_after_kill");

        // kill coinciding with accept
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        chk("kill_accept_flags", {in_ready, out_valid, busy}, 3'b100);

        // kill in DONE outranks the handshake
        @(negedge clk);
        in_valid = 1'b1; op = 3'b101; a = 32'd9; b = 32'd0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_hold_result", {out_valid, result}, {1'b1, 32'hFFFF_FFFF});
        kill = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_done_flags", {in_ready, out_valid, busy, result}, {3'b100, 32'd0});

        // asynchronous reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; a = 32'd7; b = 32'd9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_flags", {in_ready, busy, out_valid}, 3'b100);
        chk("async_rst_result", result, 32'd0);
        #1 rst = 1'b0;
        run_op(3'b000, 32'd7, 32'd9, 32'd63, 34, "mul_after_rst");

        // WIDTH=8 divide with back-pressure
        @(negedge clk);
        in_valid_8 = 1'b1; op_8 = 3'b101; a_8 = 8'd200; b_8 = 8'd7; out_ready_8 = 1'b0;
        sb8_q.push_back(8'h1C);
        @(posedge clk);
        #1;
        in_valid_8 = 1'b0; a_8 = 8'($urandom); b_8 = 8'($urandom); op_8 = 3'($urandom);
        lat = 0;
        while (lat < 50 && !out_valid_8) begin
            @(negedge clk);
            lat++;
        end
        exp8 = sb8_q.pop_front();
        chk("w8_latency", lat, 10);
        chk("w8_result", result_8, exp8);
        held = 0;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid_8) held++;
            if (result_8 !== exp8) stable = 1'b0;
        end
        chk("w8_held_cycles", held, 5);
        chk("w8_result_stable", stable, 1);
        out_ready_8 = 1'b1;
        @(negedge clk);
        chk("w8_idle_after", {in_ready_8, out_valid_8, busy_8, result_8}, {3'b100, 8'd0});
        out_ready_8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; legal values 4..64.
REQ-002 Port clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port in_valid  input  1  request valid.
REQ-005 Port in_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 Port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port a  input  WIDTH  operand rs1 / dividend.
REQ-008 Port b  input  WIDTH  operand rs2 / divisor.
REQ-009 Port kill  input  1  abort the in-flight operation.
REQ-010 Port out_valid  output  1  result valid.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port result  output  WIDTH  operation result.
REQ-013 Port busy  output  1  high in any state other than IDLE.

Function
REQ-014 Accept: handshake in the cycle where in_valid && in_ready. At that clock edge the unit latches op, a and b, and leaves IDLE.
REQ-015 States: IDLE, CALC, FIX, DONE.
REQ-016 Accept with a normal operand pair: IDLE -> CALC.
REQ-017 Accept with a special case (REQ-023, REQ-024): IDLE -> DONE.
REQ-018 CALC runs exactly WIDTH cycles, one bit per cycle, counted by a bit counter.
  - Multiply: shift-add on operand magnitudes, producing a 2*WIDTH-bit product.
  - Divide: restoring division on operand magnitudes.
REQ-019 CALC -> FIX when the bit counter reaches WIDTH-1.
  - FIX applies sign correction and selects the result half.
  - FIX -> DONE unconditionally.
REQ-020 Latency: out_valid rises WIDTH+2 cycles after the accept edge for normal operations, and 1 cycle after it for special cases.
REQ-021 DONE: out_valid=1 and result held stable until out_valid && out_ready, then DONE -> IDLE.
  - in_ready stays 0 in DONE, so no request is accepted in the same cycle as a result handshake.
REQ-022 Signedness and result selection:
  - MUL: low WIDTH bits of the product.
  - MULH: high WIDTH bits, a and b signed.
  - MULHSU: high WIDTH bits, a signed, b unsigned.
  - MULHU: high WIDTH bits, both unsigned.
  - DIV/REM: signed. Quotient is truncated toward zero; remainder takes the sign of the dividend.
  - DIVU/REMU: unsigned.
REQ-023 Divide by zero (b==0, op 1xx): quotient = all ones; remainder = a.
REQ-024 Signed overflow (DIV/REM, a = most-negative value, b = all ones): quotient = a; remainder = 0.
REQ-025 kill: while kill=1 in CALC, FIX or DONE, next state is IDLE and out_valid=0 next cycle.
  - No result is delivered for the killed operation.
  - kill in IDLE has no effect.
  - kill takes priority over the result handshake.
REQ-026 If kill=1 in the same cycle as an accept handshake, the request is dropped and the state stays IDLE.
REQ-027 Operand inputs are ignored outside the accept cycle; changing a, b or op mid-operation does not affect the result.
REQ-028 result is 0 whenever out_valid=0.

Reset
REQ-029 rst asserted, at any time including mid-CALC: state=IDLE, in_ready=1, busy=0, out_valid=0, result=0, bit counter=0, internal registers=0, all immediately and without waiting for clk.
REQ-030 Following rst deassertion, a request may be accepted at the first rising clk edge.

Verification
REQ-031 WIDTH=32, MUL a=0xFFFFFFFF b=0x00000002, out_ready=1 -> out_valid 34 cycles after accept; result=0xFFFFFFFE.
REQ-032 WIDTH=32, MULH/MULHSU/MULHU with a=0x80000000 b=0xFFFFFFFF -> results 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
REQ-033 WIDTH=32, DIV a=-7 b=2 -> 0xFFFFFFFD; REM a=-7 b=2 -> 0xFFFFFFFF; DIVU a=7 b=0 -> 0xFFFFFFFF, 1-cycle latency; DIV a=0x80000000 b=-1 -> 0x80000000.
REQ-034 WIDTH=8, DIVU a=200 b=7 with out_ready held 0 for 5 cycles -> result=28 (0x1C), out_valid held 5+ cycles, then IDLE the cycle after out_ready=1.
REQ-035 kill pulsed at CALC cycle 10 -> out_valid never asserts; in_ready=1 next cycle; a following MUL 3*5 returns 15.
REQ-036 rst asserted asynchronously mid-CALC -> out_valid=0, busy=0 and in_ready=1 before the next clk edge.
